// File: rtl/sc_cmd_sequencer_pkg.sv
// rtl/sc_cmd_sequencer_pkg.sv - shared constants, opcodes and state encoding for the command sequencer
package sc_cmd_sequencer_pkg;

    localparam int DWIDTH      = 8;
    localparam int SEQ_CNT_W   = 8;
    localparam int SEQ_TIMEOUT = 255;

    localparam logic [DWIDTH-1:0] OP_NOP    = 8'h00;
    localparam logic [DWIDTH-1:0] OP_WRSTAT = 8'h10;
    localparam logic [DWIDTH-1:0] OP_BURST  = 8'h20;
    localparam logic [DWIDTH-1:0] OP_CLRERR = 8'h30;

    // Status bit that enables the downstream strobe during a burst
    localparam int                STRB_EN_BIT = 3;
    localparam logic [DWIDTH-1:0] STRB_MASK   = DWIDTH'(1) << STRB_EN_BIT;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARG1 = 3'd1,
        ST_ARG2 = 3'd2,
        ST_LOAD = 3'd3,
        ST_RUN  = 3'd4,
        ST_STOP = 3'd5
    } seq_state_e;

endpackage

// File: rtl/sc_cmd_sequencer_if.sv
// rtl/sc_cmd_sequencer_if.sv - host byte handshake and status-load bus bundle
interface sc_cmd_sequencer_if #(
    parameter int DWIDTH = sc_cmd_sequencer_pkg::DWIDTH
);
    logic              CS_Valid;
    logic [DWIDTH-1:0] CS_Byte;
    logic              CS_Ready;
    logic              SC_Fifo_Full;
    logic              SC_CmdN;
    logic [DWIDTH-1:0] SC_Data_Bus;
    logic [DWIDTH-1:0] SEQ_Status;
    logic              SEQ_Busy;
    logic              SEQ_Err;

    // Host / environment side
    modport master (
        output CS_Valid, CS_Byte, SC_Fifo_Full,
        input  CS_Ready, SC_CmdN, SC_Data_Bus, SEQ_Status, SEQ_Busy, SEQ_Err
    );

    // Sequencer side
    modport slave (
        input  CS_Valid, CS_Byte, SC_Fifo_Full,
        output CS_Ready, SC_CmdN, SC_Data_Bus, SEQ_Status, SEQ_Busy, SEQ_Err
    );

endinterface

// File: rtl/sc_cmd_sequencer_seq_counter.sv
// rtl/sc_cmd_sequencer_seq_counter.sv - loadable down-counter with enable and terminal-count flag
module sc_seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             SC_IClk,
    input  logic             SC_ResetN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over decrement; a loaded 0 wraps so it behaves as 2**WIDTH
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge SC_IClk or negedge SC_ResetN) begin
        if (!SC_ResetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count marks the step that takes the counter from 1 to 0
    assign tc = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/sc_cmd_sequencer.sv
// rtl/sc_cmd_sequencer.sv - host command sequencer driving status loads and timed strobe bursts
module sc_cmd_sequencer #(
    parameter int CNT_W   = sc_cmd_sequencer_pkg::SEQ_CNT_W,
    parameter int TIMEOUT = sc_cmd_sequencer_pkg::SEQ_TIMEOUT
) (
    input logic               SC_IClk,
    input logic               SC_ResetN,
    sc_cmd_sequencer_if.slave bus
);
    import sc_cmd_sequencer_pkg::*;

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

    seq_state_e        state_q, state_d;
    logic              is_burst_q, is_burst_d;
    logic [DWIDTH-1:0] value_q, value_d;
    logic              cmd_n_q, cmd_n_d;
    logic [DWIDTH-1:0] data_bus_q, data_bus_d;
    logic [DWIDTH-1:0] status_q, status_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic              handshake;
    logic              load_issue;
    logic [DWIDTH-1:0] load_val;
    logic              burst_load, burst_en, burst_tc;
    logic              tmo_load, tmo_en, tmo_tc;

    assign handshake = bus.CS_Valid & ready_q;

    sc_seq_counter #(.WIDTH(CNT_W)) u_burst_cnt (
        .SC_IClk   (SC_IClk),
        .SC_ResetN (SC_ResetN),
        .load      (burst_load),
        .load_val  (CNT_W'(bus.CS_Byte)),
        .en        (burst_en),
        .tc        (burst_tc)
    );

    sc_seq_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
        .SC_IClk   (SC_IClk),
        .SC_ResetN (SC_ResetN),
        .load      (tmo_load),
        .load_val  (TMO_LOAD),
        .en        (tmo_en),
        .tc        (tmo_tc)
    );

    // Next-state, load scheduling and flag updates
    always_comb begin
        state_d    = state_q;
        is_burst_d = is_burst_q;
        value_d    = value_q;
        cmd_n_d    = 1'b1;
        data_bus_d = data_bus_q;
        status_d   = status_q;
        err_d      = err_q;
        load_issue = 1'b0;
        load_val   = value_q;
        burst_load = 1'b0;
        burst_en   = 1'b0;
        tmo_load   = 1'b0;
        tmo_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    case (bus.CS_Byte)
                        OP_NOP: begin
                        end
                        OP_WRSTAT: begin
                            is_burst_d = 1'b0;
                            tmo_load   = 1'b1;
                            state_d    = ST_ARG1;
                        end
                        OP_BURST: begin
                            is_burst_d = 1'b1;
                            tmo_load   = 1'b1;
                            state_d    = ST_ARG1;
                        end
                        OP_CLRERR: begin
                            err_d = 1'b0;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_ARG1: begin
                if (handshake) begin
                    tmo_load = 1'b1;
                    if (is_burst_q) begin
                        value_d = bus.CS_Byte | STRB_MASK;
                        state_d = ST_ARG2;
                    end else begin
                        value_d    = bus.CS_Byte;
                        load_issue = 1'b1;
                        load_val   = bus.CS_Byte;
                        state_d    = ST_LOAD;
                    end
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_tc) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ARG2: begin
                if (handshake) begin
                    burst_load = 1'b1;
                    load_issue = 1'b1;
                    load_val   = value_q;
                    state_d    = ST_LOAD;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_tc) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOAD: begin
                state_d = is_burst_q ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!bus.SC_Fifo_Full) begin
                    burst_en = 1'b1;
                    if (burst_tc) begin
                        load_issue = 1'b1;
                        load_val   = status_q & ~STRB_MASK;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loads are registered so SC_CmdN and the bus change together in the load cycle
        if (load_issue) begin
            cmd_n_d    = 1'b0;
            data_bus_d = load_val;
            status_d   = load_val;
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_ARG1) || (state_d == ST_ARG2);
    end

    // State and output registers
    always_ff @(posedge SC_IClk or negedge SC_ResetN) begin
        if (!SC_ResetN) begin
            state_q    <= ST_IDLE;
            is_burst_q <= 1'b0;
            value_q    <= '0;
            cmd_n_q    <= 1'b1;
            data_bus_q <= '0;
            status_q   <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_burst_q <= is_burst_d;
            value_q    <= value_d;
            cmd_n_q    <= cmd_n_d;
            data_bus_q <= data_bus_d;
            status_q   <= status_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.CS_Ready    = ready_q;
    assign bus.SC_CmdN     = cmd_n_q;
    assign bus.SC_Data_Bus = data_bus_q;
    assign bus.SEQ_Status  = status_q;
    assign bus.SEQ_Busy    = (state_q != ST_IDLE);
    assign bus.SEQ_Err     = err_q;

endmodule

// File: tb/tb_sc_cmd_sequencer.sv
// tb/tb_sc_cmd_sequencer.sv - scoreboard bench for the command sequencer
module tb_sc_cmd_sequencer;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sc_cmd_sequencer_if bus ();

    sc_cmd_sequencer dut (
        .SC_IClk   (clk),
        .SC_ResetN (rstn),
        .bus       (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];
    int         load_t[$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Cycle index used to time load pulses
    always @(posedge clk) cyc++;

    // Monitor: every load cycle pops one expected value from the scoreboard
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.SC_CmdN === 1'b0) begin
            load_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_load data=%0h expected no load", bus.SC_Data_Bus);
            end else begin
                mon_exp = exp_q.pop_front();
                check("load_data", 32'(bus.SC_Data_Bus), 32'(mon_exp));
                check("load_status", 32'(bus.SEQ_Status), 32'(mon_exp));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.CS_Valid = 1'b1;
        bus.CS_Byte  = b;
        while (bus.CS_Ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.CS_Ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%0h ready=%b expected 1", b, bus.CS_Ready);
        end
        @(posedge clk);
        #1;
        bus.CS_Valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (bus.SEQ_Busy !== 1'b0 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_falls", 32'(bus.SEQ_Busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmdn"},   32'(bus.SC_CmdN),     32'd1);
        check({tag, "_data"},   32'(bus.SC_Data_Bus), 32'd0);
        check({tag, "_status"}, 32'(bus.SEQ_Status),  32'd0);
        check({tag, "_busy"},   32'(bus.SEQ_Busy),    32'd0);
        check({tag, "_err"},    32'(bus.SEQ_Err),     32'd0);
        check({tag, "_ready"},  32'(bus.CS_Ready),    32'd0);
    endtask

    task automatic run_burst(input logic [7:0] v, input logic [7:0] c, input logic [7:0] e_on,
                             input logic [7:0] e_off, input int stall, input int run_len);
        exp_q.push_back(e_on);
        exp_q.push_back(e_off);
        load_t.delete();
        send_byte(8'h20);
        send_byte(v);
        send_byte(c);
        if (stall > 0) begin
            @(posedge clk);
            #1;
            bus.SC_Fifo_Full = 1'b1;
            repeat (stall) @(posedge clk);
            #1;
            bus.SC_Fifo_Full = 1'b0;
        end
        wait_idle(400);
        check("burst_loads", 32'(load_t.size()), 32'd2);
        if (load_t.size() == 2) check("burst_gap", 32'(load_t[1] - load_t[0]), 32'(run_len + 1));
        check("burst_status", 32'(bus.SEQ_Status), 32'(e_off));
    endtask

    initial begin
        rstn             = 1'b0;
        bus.CS_Valid     = 1'b0;
        bus.CS_Byte      = 8'h00;
        bus.SC_Fifo_Full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // WRSTAT back-to-back
        exp_q.push_back(8'h25);
        send_byte(8'h10);
        send_byte(8'h25);
        check("wr_cmdn_low", 32'(bus.SC_CmdN), 32'd0);
        check("wr_busy_in_load", 32'(bus.SEQ_Busy), 32'd1);
        @(posedge clk);
        #1;
        check("wr_cmdn_high", 32'(bus.SC_CmdN), 32'd1);
        check("wr_idle", 32'(bus.SEQ_Busy), 32'd0);
        check("wr_bus_hold", 32'(bus.SC_Data_Bus), 32'h25);

        // NOP stays idle
        send_byte(8'h00);
        check("nop_idle", 32'(bus.SEQ_Busy), 32'd0);

        // Bursts: plain, stalled, count of zero
        run_burst(8'h11, 8'h04, 8'h19, 8'h11, 0, 4);
        run_burst(8'h11, 8'h04, 8'h19, 8'h11, 3, 7);
        run_burst(8'h08, 8'h00, 8'h08, 8'h00, 0, 256);

        // Illegal opcode, then argument timeout
        load_t.delete();
        send_byte(8'h7F);
        check("bad_op_err", 32'(bus.SEQ_Err), 32'd1);
        check("bad_op_idle", 32'(bus.SEQ_Busy), 32'd0);
        send_byte(8'h10);
        repeat (254) @(posedge clk);
        #1;
        check("tmo_still_waiting", 32'(bus.SEQ_Busy), 32'd1);
        @(posedge clk);
        #1;
        check("tmo_idle", 32'(bus.SEQ_Busy), 32'd0);
        check("tmo_err", 32'(bus.SEQ_Err), 32'd1);
        check("tmo_no_load", 32'(load_t.size()), 32'd0);

        // Valid command executes with the error flag set; flag stays sticky
        exp_q.push_back(8'h5A);
        send_byte(8'h10);
        send_byte(8'h5A);
        @(posedge clk);
        #1;
        check("sticky_err", 32'(bus.SEQ_Err), 32'd1);
        check("sticky_status", 32'(bus.SEQ_Status), 32'h5A);
        send_byte(8'h30);
        check("clrerr", 32'(bus.SEQ_Err), 32'd0);

        // Reset in the middle of a burst
        send_byte(8'h7F);
        exp_q.push_back(8'h3B);
        load_t.delete();
        send_byte(8'h20);
        send_byte(8'h33);
        send_byte(8'h10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(bus.SEQ_Busy), 32'd1);
        check("pre_reset_err", 32'(bus.SEQ_Err), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrun_one_load", 32'(load_t.size()), 32'd1);
        check("midrun_idle", 32'(bus.SEQ_Busy), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
